if_id_buffer: RTL and testbench
===============================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning entry count; legal values 2, 4, 8.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the out_instr value driven while empty.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the IF stage presents a fetched instruction.
REQ-006 SHALL have port in_ready, output, 1, meaning the buffer accepts a push this cycle.
REQ-007 SHALL have port in_pc, input, 32, meaning the PC of the presented instruction.
REQ-008 SHALL have port in_instr, input, 32, meaning the presented instruction word.
REQ-009 SHALL have port flush, input, 1, meaning discard all entries (driven with IF redirect_valid).
REQ-010 SHALL have port out_valid, output, 1, meaning the head entry is valid for ID.
REQ-011 SHALL have port out_ready, input, 1, meaning ID consumes the head this cycle.
REQ-012 SHALL have port out_pc, output, 32, meaning the head entry PC.
REQ-013 SHALL have port out_instr, output, 32, meaning the head entry instruction.
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1, meaning the number of occupied entries.

Function
REQ-015 SHALL implement a circular FIFO of DEPTH entries, each holding {pc, instr}, with read and write pointers wrapping modulo DEPTH.
REQ-016 SHALL define push as in_valid && in_ready && !flush and pop as out_valid && out_ready && !flush.
REQ-017 SHALL drive in_ready = (count < DEPTH), with no combinational dependence on out_ready.
REQ-018 SHALL drive out_valid = (count != 0).
REQ-019 SHALL drive out_pc and out_instr directly from the head entry storage; when count == 0 they SHALL be 32'h0 and NOP_INSTR.
REQ-020 SHALL produce one-cycle latency: data pushed at edge N is visible on out_* after that edge, with out_valid high in the same cycle.
REQ-021 SHALL keep count unchanged on a simultaneous push and pop, including when count == 1, where the head advances to the newly pushed entry.
REQ-022 SHALL, when full, deassert in_ready even if pop occurs in the same cycle; push and pop are never simultaneous when full.
REQ-023 SHALL ignore pop when empty, with no pointer movement and no count underflow.
REQ-024 SHALL, on flush, set count, read pointer and write pointer to 0 at the next edge; any push or pop in that cycle is discarded.
REQ-025 SHALL leave entry storage contents unchanged on flush and reset; only the pointers and count are cleared.
REQ-026 SHALL hold head data stable while out_valid && !out_ready && !flush.
REQ-027 SHALL not modify the in_pc/in_instr values it stores; there is no decode or alignment check.

Reset
REQ-028 SHALL, while reset is high at a rising edge, set count = 0, both pointers = 0, out_valid = 0, in_ready = 1, out_pc = 0 and out_instr = NOP_INSTR.
REQ-029 SHALL give reset priority over flush, push and pop.
REQ-030 SHALL discard all buffered entries when reset is asserted mid-operation, with no entry emitted afterwards.

Verification
REQ-031 Reset, then push {pc 0x0, instr 0x00000013} with out_ready=0 -> next cycle out_valid=1, out_pc=0x0, count=1.
REQ-032 Push pc 0x0 and 0x4 with out_ready=0 -> count=2, in_ready=0, a third push of pc 0x8 is dropped; raising out_ready pops 0x0 then 0x4, in order.
REQ-033 With count=1 (head pc 0x4), push pc 0x8 and pop in the same cycle -> count=1, out_pc=0x8.
REQ-034 With count=2, assert flush together with in_valid (pc 0x100) -> next cycle count=0, out_valid=0, out_instr=0x00000013; the following push of pc 0x100 appears alone.
REQ-035 Fill, pop and push more than 2*DEPTH times with pcs 0x0, 0x4, ... -> out_pc sequence is contiguous with no loss or duplication across pointer wrap.
REQ-036 Assert reset with count=2 -> next cycle count=0 and in_ready=1; an out_ready pulse on an empty buffer leaves count at 0.

Source files
------------

// File: rtl/if_id_buffer.sv
// Fetch-to-decode decoupling buffer: a small circular FIFO of {pc, instr} pairs
// between the IF and ID stages. Supports flush on redirect and a NOP bubble while empty.
module if_id_buffer #(
   parameter int          DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_pc,
   input  logic [31:0]                in_instr,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_instr,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

   logic [31:0]      mem_pc_q    [DEPTH];
   logic [31:0]      mem_instr_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push, pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      next_ptr = (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // in_ready depends only on occupancy, so a full buffer never accepts a push even
   // while popping; this keeps the ready path free of any out_ready timing arc.
   assign in_ready  = (count_q < DEPTH_C);
   assign out_valid = (count_q != '0);
   assign out_pc    = out_valid ? mem_pc_q[rd_ptr_q]    : 32'h0;
   assign out_instr = out_valid ? mem_instr_q[rd_ptr_q] : NOP_INSTR;
   assign count     = count_q;

   assign push = in_valid  && in_ready  && !flush;
   assign pop  = out_valid && out_ready && !flush;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = next_ptr(wr_ptr_q);
         if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately left out of reset and flush; only occupancy gates the outputs.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_pc_q[wr_ptr_q]    <= in_pc;
         mem_instr_q[wr_ptr_q] <= in_instr;
      end
   end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer at the default DEPTH of 2.
module tb_if_id_buffer;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_pc, in_instr, out_pc, out_instr;
   logic [1:0]  count;

   int total = 0;
   int bad   = 0;

   if_id_buffer #(.DEPTH(2), .NOP_INSTR(NOP)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .count(count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      int          mcnt;
      logic [31:0] next_push, exp_pop;
      logic        mpush, mpop;

      reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_pc = 32'h0; in_instr = 32'h0;
      tick();
      tick();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_instr", out_instr, NOP);
      reset = 1'b0;

      // single push, one-cycle latency
      in_valid = 1'b1; in_pc = 32'h0; in_instr = 32'h0000_0013;
      tick();
      in_valid = 1'b0;
      chk("p1_out_valid", 32'(out_valid), 32'd1);
      chk("p1_out_pc", out_pc, 32'h0);
      chk("p1_count", 32'(count), 32'd1);

      // fill, drop when full, drain in order
      in_valid = 1'b1; in_pc = 32'h4; in_instr = 32'hAAAA_0004;
      tick();
      chk("full_count", 32'(count), 32'd2);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      in_pc = 32'h8; in_instr = 32'hAAAA_0008;
      tick();
      in_valid = 1'b0;
      chk("drop_count", 32'(count), 32'd2);
      chk("hold_out_pc", out_pc, 32'h0);
      out_ready = 1'b1;
      #1;
      chk("pop0_pc", out_pc, 32'h0);
      tick();
      chk("pop1_pc", out_pc, 32'h4);
      chk("pop1_instr", out_instr, 32'hAAAA_0004);
      chk("pop1_count", 32'(count), 32'd1);

      // simultaneous push and pop at count 1
      in_valid = 1'b1; in_pc = 32'h8; in_instr = 32'hAAAA_0008;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("pp_count", 32'(count), 32'd1);
      chk("pp_out_pc", out_pc, 32'h8);
      chk("pp_out_instr", out_instr, 32'hAAAA_0008);

      // full with pop: push must still be refused
      in_valid = 1'b1; in_pc = 32'hC; in_instr = 32'hAAAA_000C;
      tick();
      chk("f2_count", 32'(count), 32'd2);
      in_pc = 32'h10; in_instr = 32'hAAAA_0010; out_ready = 1'b1;
      #1;
      chk("fullpop_in_ready", 32'(in_ready), 32'd0);
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("fullpop_count", 32'(count), 32'd1);
      chk("fullpop_pc", out_pc, 32'hC);

      // flush with a concurrent push and pop
      in_valid = 1'b1; in_pc = 32'h10; in_instr = 32'hAAAA_0010;
      tick();
      chk("pre_flush_count", 32'(count), 32'd2);
      flush = 1'b1; in_pc = 32'h100; in_instr = 32'h0012_3456; out_ready = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_out_instr", out_instr, NOP);
      chk("flush_out_pc", out_pc, 32'h0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("post_flush_count", 32'(count), 32'd1);
      chk("post_flush_pc", out_pc, 32'h100);
      chk("post_flush_instr", out_instr, 32'h0012_3456);
      out_ready = 1'b1;
      tick();
      chk("drain_count", 32'(count), 32'd0);
      tick();
      out_ready = 1'b0;
      chk("empty_pop_count", 32'(count), 32'd0);
      chk("empty_pop_valid", 32'(out_valid), 32'd0);

      // streaming across several pointer wraps
      mcnt = 0; next_push = 32'h0; exp_pop = 32'h0;
      for (int i = 0; i < 24; i++) begin
         in_valid  = (next_push < 32'h40);
         in_pc     = next_push;
         in_instr  = next_push ^ 32'hDEAD_0000;
         out_ready = ((i % 3) != 0);
         #1;
         chk("str_in_ready", 32'(in_ready), 32'(mcnt < 2));
         mpush = in_valid && (mcnt < 2);
         mpop  = out_ready && (mcnt > 0);
         if (mpop) begin
            chk("str_pc", out_pc, exp_pop);
            chk("str_instr", out_instr, exp_pop ^ 32'hDEAD_0000);
         end
         tick();
         if (mpush) begin
            next_push = next_push + 32'h4;
            mcnt++;
         end
         if (mpop) begin
            exp_pop = exp_pop + 32'h4;
            mcnt--;
         end
         chk("str_count", 32'(count), 32'(mcnt));
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("str_progress", 32'(exp_pop >= 32'h20), 32'd1);

      // reset mid-operation, with a concurrent push to test priority
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 32'h200; in_instr = 32'h0000_0200;
      tick();
      in_pc = 32'h204; in_instr = 32'h0000_0204;
      tick();
      chk("pre_rst_count", 32'(count), 32'd2);
      reset = 1'b1; in_pc = 32'h208;
      tick();
      reset = 1'b0; in_valid = 1'b0;
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_instr", out_instr, NOP);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("rst_empty_pop_count", 32'(count), 32'd0);
      chk("rst_empty_pop_pc", out_pc, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
